// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   - RV32I load/store funct3 encodings
//   - data-memory access-size codes
//   - FSM state type
//   - default data-memory window
package mem_pkg;

  localparam logic [31:0] MEM_BASE_DEFAULT  = 32'h0100_0000;
  localparam int unsigned MEM_DEPTH_DEFAULT = 1048576;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [1:0] ACC_BYTE = 2'b00;
  localparam logic [1:0] ACC_HALF = 2'b01;
  localparam logic [1:0] ACC_WORD = 2'b10;

  typedef enum logic {IDLE, SPLIT} state_e;

  // Byte count of an access from funct3[1:0].
  function automatic logic [2:0] acc_bytes(input logic [1:0] f3_lo);
    case (f3_lo)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [1:0] acc_size(input logic [1:0] f3_lo);
    case (f3_lo)
      2'd0:    return ACC_BYTE;
      2'd1:    return ACC_HALF;
      default: return ACC_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Load-data extender (combinational).
//   funct3_i : load funct3 (LB/LH/LW/LBU/LHU)
//   raw_i    : raw little-endian load data, right-aligned
//   data_o   : sign- or zero-extended 32-bit result
module mem_load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] raw_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{raw_i[7]}}, raw_i[7:0]};
      F3_LH:   data_o = {{16{raw_i[15]}}, raw_i[15:0]};
      F3_LBU:  data_o = {24'h0, raw_i[7:0]};
      F3_LHU:  data_o = {16'h0, raw_i[15:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit.
// Accepts one load/store per handshake (req_*), drives the byte-addressed data memory (mem_*),
// splits misaligned accesses into one byte access per cycle while holding stall, and registers
// the retired result onto the MEM/WB boundary (wb_*).
//   clock/reset : rising-edge clock, asynchronous active-high reset
//   req_*       : request from EX/MEM; req_ready is high only in IDLE
//   mem_*       : data-memory address/data/write-enable/size; mem_data_out is a combinational read
//   stall       : freezes IF/ID/EX during a split access
//   wb_*        : one-cycle retire pulse with load result or fault flag
module mem_access_unit
  import mem_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = MEM_BASE_DEFAULT,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  output logic [1:0]  mem_access_size,
  input  logic [31:0] mem_data_out,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_fault
);

  localparam logic [32:0] MemLimit = 33'(MEM_BASE) + 33'(MEM_DEPTH);

  state_e      state_q;
  logic [31:0] addr_q, wdata_q, buf_q, buf_d;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic [4:0]  rd_q;
  logic [1:0]  k_q;

  logic [2:0]  n_bytes;
  logic [32:0] end_addr;
  logic        illegal_f3, fault, misaligned, accept, split_last;
  logic [2:0]  ext_funct3;
  logic [31:0] ext_raw, ext_data;

  assign n_bytes    = acc_bytes(req_funct3[1:0]);
  assign end_addr   = {1'b0, req_addr} + 33'(n_bytes);
  assign illegal_f3 = req_load ? (req_funct3 == 3'd3 || req_funct3 >= 3'd6)
                               : (req_funct3 >= 3'd3);
  // Range check is done 33 bits wide so an access running past 2^32 cannot wrap into range.
  assign fault      = (req_load == req_store) || illegal_f3 || (req_addr < MEM_BASE) ||
                      (end_addr > MemLimit);
  assign misaligned = (n_bytes == 3'd2 && req_addr[0]) || (n_bytes == 3'd4 && |req_addr[1:0]);
  assign accept     = req_valid && (state_q == IDLE);
  assign split_last = (k_q == ((funct3_q[1:0] == 2'd1) ? 2'd1 : 2'd3));

  assign req_ready  = (state_q == IDLE);
  assign stall      = (state_q == SPLIT);

  // Buffer with the byte arriving this cycle merged in; the final byte's edge retires this value.
  always_comb begin
    buf_d = buf_q;
    buf_d[{k_q, 3'b000} +: 8] = mem_data_out[7:0];
  end

  assign ext_funct3 = (state_q == SPLIT) ? funct3_q : req_funct3;
  assign ext_raw    = (state_q == SPLIT) ? buf_d : mem_data_out;

  mem_load_extend u_extend (
    .funct3_i (ext_funct3),
    .raw_i    (ext_raw),
    .data_o   (ext_data)
  );

  always_comb begin
    mem_address     = MEM_BASE;
    mem_data_in     = 32'h0;
    mem_read_write  = 1'b0;
    mem_access_size = ACC_WORD;
    if (state_q == SPLIT) begin
      mem_address     = addr_q + 32'(k_q);
      mem_access_size = ACC_BYTE;
      mem_read_write  = store_q;
      mem_data_in     = {24'h0, wdata_q[{k_q, 3'b000} +: 8]};
    end else if (accept && !fault) begin
      mem_address    = req_addr;
      mem_read_write = req_store;
      if (misaligned) begin
        // Byte 0 of a split access goes out straight from the live request.
        mem_access_size = ACC_BYTE;
        mem_data_in     = {24'h0, req_wdata[7:0]};
      end else begin
        mem_access_size = acc_size(req_funct3[1:0]);
        mem_data_in     = req_wdata;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      rd_q     <= '0;
      k_q      <= '0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_fault <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_fault <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (fault) begin
              wb_valid <= 1'b1;
              wb_fault <= 1'b1;
              wb_rd    <= '0;
              wb_data  <= '0;
            end else if (misaligned) begin
              state_q  <= SPLIT;
              addr_q   <= req_addr;
              wdata_q  <= req_wdata;
              funct3_q <= req_funct3;
              store_q  <= req_store;
              rd_q     <= req_rd;
              k_q      <= 2'd1;
              buf_q    <= {24'h0, mem_data_out[7:0]};
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= req_load;
              wb_rd    <= req_load ? req_rd : 5'd0;
              wb_data  <= req_load ? ext_data : 32'h0;
            end
          end
        end
        SPLIT: begin
          buf_q <= buf_d;
          if (split_last) begin
            state_q  <= IDLE;
            wb_valid <= 1'b1;
            wb_we    <= !store_q;
            wb_rd    <= store_q ? 5'd0 : rd_q;
            wb_data  <= store_q ? 32'h0 : ext_data;
          end else begin
            k_q <= k_q + 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int unsigned DEPTH = 1048576;

  logic        clock, reset;
  logic        req_valid, req_ready, req_load, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write;
  logic [1:0]  mem_access_size;
  logic        stall, wb_valid, wb_we, wb_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_access_unit #(.MEM_BASE(BASE), .MEM_DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_load        (req_load),
    .req_store       (req_store),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_rd          (req_rd),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .mem_read_write  (mem_read_write),
    .mem_access_size (mem_access_size),
    .mem_data_out    (mem_data_out),
    .stall           (stall),
    .wb_valid        (wb_valid),
    .wb_we           (wb_we),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .wb_fault        (wb_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- data memory seen by the DUT ----------------
  logic [7:0]  env_mem [int unsigned];
  logic [7:0]  ref_mem [int unsigned];
  int unsigned mem_gen = 0;
  logic [31:0] mem_rdata = 32'h0;
  assign mem_data_out = mem_rdata;

  function automatic logic [7:0] env_byte(input int unsigned idx);
    return env_mem.exists(idx) ? env_mem[idx] : 8'h00;
  endfunction
  function automatic logic [7:0] ref_byte(input int unsigned idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 8'h00;
  endfunction

  always @(mem_address or mem_access_size or mem_gen) begin : mem_read
    int nb;
    int unsigned idx;
    nb = (mem_access_size == 2'b00) ? 1 : (mem_access_size == 2'b01) ? 2 : 4;
    idx = mem_address - BASE;
    mem_rdata = 32'h0;
    if (mem_address >= BASE && longint'(idx) + nb <= longint'(DEPTH))
      for (int i = 0; i < nb; i++) mem_rdata[8*i +: 8] = env_byte(idx + i);
  end

  always @(posedge clock) begin : mem_write
    int nb;
    int unsigned idx;
    nb = (mem_access_size == 2'b00) ? 1 : (mem_access_size == 2'b01) ? 2 : 4;
    idx = mem_address - BASE;
    if (mem_read_write && mem_address >= BASE && longint'(idx) + nb <= longint'(DEPTH)) begin
      for (int i = 0; i < nb; i++) env_mem[idx + i] = mem_data_in[8*i +: 8];
      mem_gen++;
    end
  end

  task automatic preload(input int unsigned off, input logic [7:0] b);
    env_mem[off] = b;
    ref_mem[off] = b;
    mem_gen++;
  endtask

  // ---------------- transaction-level model and scoreboard ----------------
  typedef struct {
    int          cyc;
    bit          fault;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        expq[$];
  int          stall_lo = 1, stall_hi = 0;
  bit          chk_en = 1'b0;
  logic [31:0] last_data = 32'h0;
  logic        last_fault = 1'b0;

  always @(negedge clock) begin : compare
    bit   exp_v, exp_stall;
    exp_t e;
    if (chk_en && !reset) begin
      exp_v = (expq.size() > 0) && (expq[0].cyc == cyc);
      chk("wb_valid", {31'h0, wb_valid}, {31'h0, exp_v});
      if (exp_v) begin
        e = expq.pop_front();
        chk("wb_fault", {31'h0, wb_fault}, {31'h0, e.fault});
        chk("wb_we", {31'h0, wb_we}, {31'h0, e.we});
        chk("wb_data", wb_data, e.data);
        if (e.we) chk("wb_rd", {27'h0, wb_rd}, {27'h0, e.rd});
        last_data  = wb_data;
        last_fault = wb_fault;
      end
      exp_stall = (cyc >= stall_lo) && (cyc <= stall_hi);
      chk("stall", {31'h0, stall}, {31'h0, exp_stall});
      chk("req_ready", {31'h0, req_ready}, {31'h0, !exp_stall});
    end
  end

  // Called away from the rising edge; returns at the negedge after the accept edge.
  task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, output int lat);
    int          n;
    bit          flt;
    exp_t        e;
    int unsigned idx;
    logic [31:0] v;
    n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    flt = (ld == st) || (ld && (f3 == 3'd3 || f3 >= 3'd6)) || (st && f3 >= 3'd3) ||
          (addr < BASE) || (longint'(addr) + n > longint'(BASE) + longint'(DEPTH));
    lat = (flt || (addr % 32'(n)) == 0) ? 1 : n;
    idx = addr - BASE;
    v   = 32'h0;
    if (!flt && st) for (int i = 0; i < n; i++) ref_mem[idx + i] = wdata[8*i +: 8];
    if (!flt && ld) begin
      for (int i = 0; i < n; i++) v = v | (32'(ref_byte(idx + i)) << (8 * i));
      if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    end
    e.cyc   = cyc + lat;
    e.fault = flt;
    e.we    = !flt && ld;
    e.rd    = rd;
    e.data  = v;
    expq.push_back(e);
    if (lat > 1) begin
      stall_lo = cyc + 1;
      stall_hi = cyc + lat - 1;
    end
    req_valid  = 1'b1;
    req_load   = ld;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    @(negedge clock);
    req_valid = 1'b0;
    req_load  = 1'b0;
    req_store = 1'b0;
  endtask

  task automatic run(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [4:0] rd);
    int lat;
    issue(ld, st, f3, addr, wdata, rd, lat);
    if (lat > 1) repeat (lat - 1) @(negedge clock);
    #1;
  endtask

  task automatic compare_mem(input int unsigned lo, input int unsigned hi);
    for (int unsigned i = lo; i <= hi; i++) chk($sformatf("mem[+%0d]", i), {24'h0, env_byte(i)},
                                               {24'h0, ref_byte(i)});
  endtask

  initial begin : stim
    int lat;
    reset = 1'b1;
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    @(negedge clock);
    chk("rst wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst wb_fault", {31'h0, wb_fault}, 32'h0);
    chk("rst stall", {31'h0, stall}, 32'h0);
    chk("rst wb_data", wb_data, 32'h0);
    chk("rst req_ready", {31'h0, req_ready}, 32'h1);
    chk("idle mem_address", mem_address, BASE);
    chk("idle mem_access_size", {30'h0, mem_access_size}, 32'h2);
    chk("idle mem_rw", {31'h0, mem_read_write}, 32'h0);
    chk("idle mem_data_in", mem_data_in, 32'h0);
    reset  = 1'b0;
    chk_en = 1'b1;

    preload(0, 8'hEF); preload(1, 8'hBE); preload(2, 8'hAD); preload(3, 8'hDE);
    preload(4, 8'h80);
    preload(7, 8'h34); preload(8, 8'h92);

    run(1, 0, F3_LW, BASE, 32'h0, 5'd5);
    chk("LW aligned", last_data, 32'hDEAD_BEEF);
    run(1, 0, F3_LB, BASE + 4, 32'h0, 5'd6);
    chk("LB sign", last_data, 32'hFFFF_FF80);
    run(1, 0, F3_LBU, BASE + 4, 32'h0, 5'd6);
    chk("LBU zero", last_data, 32'h0000_0080);
    preload(4, 8'h01); preload(5, 8'h80);
    run(1, 0, F3_LH, BASE + 4, 32'h0, 5'd9);
    chk("LH sign", last_data, 32'hFFFF_8001);
    run(1, 0, F3_LHU, BASE + 4, 32'h0, 5'd9);
    chk("LHU zero", last_data, 32'h0000_8001);
    run(1, 0, F3_LH, BASE + 7, 32'h0, 5'd10);
    chk("LH split sign", last_data, 32'hFFFF_9234);
    repeat (2) @(negedge clock);

    run(0, 1, F3_SW, BASE + 1, 32'h1122_3344, 5'd0);
    chk("SW split +1", {24'h0, env_byte(1)}, 32'h44);
    chk("SW split +2", {24'h0, env_byte(2)}, 32'h33);
    chk("SW split +3", {24'h0, env_byte(3)}, 32'h22);
    chk("SW split +4", {24'h0, env_byte(4)}, 32'h11);
    run(1, 0, F3_LW, BASE + 1, 32'h0, 5'd7);
    chk("LW split", last_data, 32'h1122_3344);
    run(1, 0, F3_LHU, BASE + 3, 32'h0, 5'd8);
    chk("LHU split", last_data, 32'h0000_1122);

    run(0, 1, F3_SW, BASE - 4, 32'hFFFF_FFFF, 5'd0);
    chk("fault below base", {31'h0, last_fault}, 32'h1);
    run(1, 0, F3_LW, BASE + DEPTH - 2, 32'h0, 5'd3);
    chk("fault past end", {31'h0, last_fault}, 32'h1);
    run(1, 1, F3_SW, BASE + 12, 32'h7777_7777, 5'd3);
    run(1, 0, 3'd3, BASE, 32'h0, 5'd3);
    run(0, 1, 3'd4, BASE + 12, 32'h6666_6666, 5'd3);
    compare_mem(0, 24);

    run(0, 1, F3_SW, BASE + DEPTH - 4, 32'h5A5A_A5A5, 5'd0);
    run(1, 0, F3_LW, BASE + DEPTH - 4, 32'h0, 5'd4);
    chk("LW top word", last_data, 32'h5A5A_A5A5);

    issue(0, 1, F3_SW, BASE + 8, 32'hCAFE_F00D, 5'd0, lat);
    issue(1, 0, F3_LW, BASE + 8, 32'h0, 5'd11, lat);
    #1;
    chk("b2b SW->LW", last_data, 32'hCAFE_F00D);

    // Reset while a split store is in flight: only byte 0 has reached memory.
    issue(0, 1, F3_SW, BASE + 17, 32'hAABB_CCDD, 5'd0, lat);
    #1 reset = 1'b1;
    #1;
    chk("reset drops stall", {31'h0, stall}, 32'h0);
    chk("reset no wb_valid", {31'h0, wb_valid}, 32'h0);
    expq.delete();
    stall_lo = 1; stall_hi = 0;
    ref_mem.delete(18); ref_mem.delete(19); ref_mem.delete(20);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("reset keeps +17", {24'h0, env_byte(17)}, 32'hDD);
    chk("reset skips +18", {24'h0, env_byte(18)}, 32'h00);
    repeat (2) @(negedge clock);
    run(1, 0, F3_LW, BASE + 8, 32'h0, 5'd12);
    chk("LW after reset", last_data, 32'hCAFE_F00D);

    compare_mem(0, 24);
    compare_mem(DEPTH - 8, DEPTH - 1);
    chk("scoreboard drained", expq.size(), 32'h0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
